// File: rtl/trg_out_ctrl_mc.sv
// Multi-source trigger output controller: merges enabled trigger edges, gates them on busy,
// drives a normal or ID-check pulse on the active-low FEE lines, then enforces dead time.
module trg_out_ctrl_mc #(
    parameter int N_SRC           = 3,
    parameter int N_BUSY          = 2,
    parameter int N_OUT           = 14,
    parameter int TRG_PULSE_WIDTH = 20,
    parameter int CHK_PULSE_WIDTH = 50,
    parameter int CHK_MOD_W       = 12,
    parameter int DT_W            = 8,
    parameter int CNT_W           = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [N_SRC-1:0]  trg_src_in,
    input  logic [N_SRC-1:0]  src_enb_in,
    input  logic              trg_enb_in,
    input  logic [N_BUSY-1:0] busy_syn_in,
    input  logic [N_BUSY-1:0] busy_mask_in,
    input  logic              pmu_busy_in,
    input  logic [DT_W-1:0]   trg_dead_time_in,
    output logic              eff_trg_out,
    output logic [N_OUT-1:0]  trg_out_N,
    output logic [N_SRC-1:0]  trg_src_latch_out,
    output logic [CNT_W-1:0]  eff_trg_cnt_out,
    output logic [CNT_W-1:0]  lost_trg_cnt_out,
    output logic              daq_busy_out
);
    localparam int PW_MAX = (CHK_PULSE_WIDTH > TRG_PULSE_WIDTH) ? CHK_PULSE_WIDTH : TRG_PULSE_WIDTH;
    localparam int PW_W   = $clog2(PW_MAX + 1);
    // One down-counter serves both the pulse width and the dead time.
    localparam int C_W    = (PW_W > DT_W) ? PW_W : DT_W;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_DEAD} state_t;

    state_t            r_state, w_state_nxt;
    logic [N_SRC-1:0]  r_prev, w_edge;
    logic [CNT_W-1:0]  w_eff_cnt_inc;
    logic [C_W-1:0]    r_cnt;
    logic [DT_W-1:0]   r_dt;
    logic              w_busy, w_accept, w_reject, w_chk;

    assign w_edge        = trg_src_in & ~r_prev & src_enb_in;
    assign w_busy        = (|(busy_syn_in & ~busy_mask_in)) | pmu_busy_in;
    assign w_accept      = (|w_edge) & trg_enb_in & ~w_busy & (r_state == S_IDLE);
    assign w_reject      = (|w_edge) & trg_enb_in & ~w_accept;
    assign w_eff_cnt_inc = eff_trg_cnt_out + 1'b1;
    assign w_chk         = (w_eff_cnt_inc[CHK_MOD_W-1:0] == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_PULSE;
            S_PULSE: if (r_cnt == C_W'(1)) w_state_nxt = (r_dt != '0) ? S_DEAD : S_IDLE;
            S_DEAD:  if (r_cnt == C_W'(1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state           <= S_IDLE;
            r_prev            <= '0;
            r_cnt             <= '0;
            r_dt              <= '0;
            eff_trg_out       <= 1'b0;
            trg_out_N         <= '1;
            trg_src_latch_out <= '0;
            eff_trg_cnt_out   <= '0;
            lost_trg_cnt_out  <= '0;
            daq_busy_out      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= trg_src_in;
            eff_trg_out  <= w_accept;
            // Lines are registered off the next state so they switch with the FSM, glitch-free.
            trg_out_N    <= {N_OUT{w_state_nxt != S_PULSE}};
            daq_busy_out <= w_busy | (r_state != S_IDLE);

            if (w_accept) begin
                eff_trg_cnt_out   <= w_eff_cnt_inc;
                trg_src_latch_out <= w_edge;
                r_dt              <= trg_dead_time_in;
                r_cnt             <= w_chk ? C_W'(CHK_PULSE_WIDTH) : C_W'(TRG_PULSE_WIDTH);
            end else if (r_state == S_PULSE) begin
                r_cnt <= (r_cnt == C_W'(1)) ? C_W'(r_dt) : r_cnt - 1'b1;
            end else if (r_state == S_DEAD) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_reject && (lost_trg_cnt_out != '1))
                lost_trg_cnt_out <= lost_trg_cnt_out + 1'b1;
        end
    end
endmodule

// File: tb/tb_trg_out_ctrl_mc.sv
// Bench for trg_out_ctrl_mc: a timestamp-based reference model checked every cycle,
// a vector table of single-trigger cases, and directed timing/wrap/reset/saturation sequences.
module tb_trg_out_ctrl_mc;
    localparam int NS = 3, NB = 2, NO = 14, TPW = 20, CPW = 50, CMW = 4, DTW = 8, CW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NS-1:0]  src, senb;
    logic           ten, pmu;
    logic [NB-1:0]  busy, mask;
    logic [DTW-1:0] dt;
    logic           eff_trg_out, daq_busy_out;
    logic [NO-1:0]  trg_out_N;
    logic [NS-1:0]  latch_out;
    logic [CW-1:0]  eff_cnt_out, lost_cnt_out;

    trg_out_ctrl_mc #(
        .N_SRC(NS), .N_BUSY(NB), .N_OUT(NO), .TRG_PULSE_WIDTH(TPW), .CHK_PULSE_WIDTH(CPW),
        .CHK_MOD_W(CMW), .DT_W(DTW), .CNT_W(CW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .trg_src_in(src), .src_enb_in(senb), .trg_enb_in(ten),
        .busy_syn_in(busy), .busy_mask_in(mask), .pmu_busy_in(pmu), .trg_dead_time_in(dt),
        .eff_trg_out(eff_trg_out), .trg_out_N(trg_out_N), .trg_src_latch_out(latch_out),
        .eff_trg_cnt_out(eff_cnt_out), .lost_trg_cnt_out(lost_cnt_out), .daq_busy_out(daq_busy_out)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: tracks time windows (edge indices) rather than an FSM.
    int            e = 0;
    int            free_at = 0, low_from = 0, low_to = -1;
    logic [NS-1:0] m_prev = '0, m_latch = '0;
    logic [CW-1:0] m_cnt = '0, m_lost = '0;
    logic          m_eff = 0, m_daq = 0, m_low = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", nm, e, act, exp);
        end
    endtask

    task automatic tick();
        logic [NS-1:0] edg;
        logic          bsy, idle, acc, rej;
        int            w;
        if (rst) begin
            m_prev = '0; m_latch = '0; m_cnt = '0; m_lost = '0;
            m_eff = 0; m_daq = 0; m_low = 0;
            free_at = e + 1; low_from = 0; low_to = -1;
        end else begin
            edg    = src & ~m_prev & senb;
            m_prev = src;
            bsy    = (|(busy & ~mask)) | pmu;
            idle   = (e >= free_at);
            acc    = (|edg) && ten && !bsy && idle;
            rej    = (|edg) && ten && !acc;
            m_daq  = bsy | !idle;
            m_eff  = acc;
            if (acc) begin
                m_cnt    = m_cnt + 1;
                m_latch  = edg;
                w        = (m_cnt % (1 << CMW) == 0) ? CPW : TPW;
                low_from = e;
                low_to   = e + w - 1;
                free_at  = e + w + int'(dt) + 1;
            end
            if (rej && m_lost != {CW{1'b1}}) m_lost = m_lost + 1;
            m_low = (e >= low_from) && (e <= low_to);
        end
        @(posedge clk);
        e++;
        #1;
        chk("m_eff", 32'(eff_trg_out), 32'(m_eff));
        chk("m_trg_n", 32'(trg_out_N), 32'({NO{~m_low}}));
        chk("m_latch", 32'(latch_out), 32'(m_latch));
        chk("m_cnt", 32'(eff_cnt_out), 32'(m_cnt));
        chk("m_lost", 32'(lost_cnt_out), 32'(m_lost));
        chk("m_daq", 32'(daq_busy_out), 32'(m_daq));
    endtask

    // Fire one source-0 trigger and measure how long the lines stay low.
    task automatic fire(output int len);
        src = 3'b001;
        tick();
        chk("fire_eff", 32'(eff_trg_out), 32'd1);
        len = (trg_out_N == '0) ? 1 : 0;
        src = '0;
        for (int j = 0; j < 200; j++) begin
            tick();
            if (trg_out_N == '1) break;
            len++;
        end
    endtask

    typedef struct {
        logic [NS-1:0] src, senb;
        logic          ten;
        logic [NB-1:0] busy, mask;
        logic          pmu;
        logic          acc, lost_inc;
        logic [NS-1:0] latch;
    } vec_t;
    vec_t vt[10];

    initial begin
        int            len;
        logic [CW-1:0] c0, l0;
        vt[0] = '{3'b001, 3'b111, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'b001};
        vt[1] = '{3'b001, 3'b111, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000};
        vt[2] = '{3'b001, 3'b111, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 3'b001};
        vt[3] = '{3'b010, 3'b111, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 3'b000};
        vt[4] = '{3'b101, 3'b111, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'b101};
        vt[5] = '{3'b001, 3'b111, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000};
        vt[6] = '{3'b011, 3'b110, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 3'b010};
        vt[7] = '{3'b001, 3'b110, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000};
        vt[8] = '{3'b100, 3'b111, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 3'b100};
        vt[9] = '{3'b010, 3'b111, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 3'b000};

        rst = 1; src = '0; senb = '1; ten = 1; busy = '0; mask = '0; pmu = 0; dt = '0;
        tick(); tick();
        chk("rst_trg_n", 32'(trg_out_N), 32'({NO{1'b1}}));
        chk("rst_cnt", 32'(eff_cnt_out), 32'd0);
        rst = 0;

        // Table: one edge attempt per record, each from a quiet idle state.
        dt = 8'd2;
        for (int i = 0; i < 10; i++) begin
            src = '0; ten = 1; senb = vt[i].senb;
            busy = vt[i].busy; mask = vt[i].mask; pmu = vt[i].pmu;
            repeat (60) tick();
            l0 = m_lost; c0 = m_cnt;
            src = vt[i].src; ten = vt[i].ten;
            tick();
            chk("vec_eff", 32'(eff_trg_out), 32'(vt[i].acc));
            chk("vec_lost", 32'(lost_cnt_out), 32'(l0 + CW'(vt[i].lost_inc)));
            chk("vec_cnt", 32'(eff_cnt_out), 32'(c0 + CW'(vt[i].acc)));
            if (vt[i].acc) chk("vec_latch", 32'(latch_out), 32'(vt[i].latch));
        end
        src = '0; ten = 1; senb = '1; busy = '0; mask = '0; pmu = 0;

        // Dead time 3: lines low 20 cycles, edge at +23 lost, edge at +24 accepted.
        dt = 8'd3;
        repeat (60) tick();
        c0 = m_cnt; l0 = m_lost;
        fire(len);
        chk("dt_low_len", 32'(len), 32'(TPW));
        repeat (2) tick();
        src = 3'b001; tick();
        chk("dt_early_eff", 32'(eff_trg_out), 32'd0);
        chk("dt_early_lost", 32'(lost_cnt_out), 32'(l0 + 1));
        src = 3'b011; tick();
        chk("dt_ok_eff", 32'(eff_trg_out), 32'd1);
        chk("dt_ok_latch", 32'(latch_out), 32'(3'b010));
        chk("dt_ok_cnt", 32'(eff_cnt_out), 32'(c0 + 2));
        src = '0;
        repeat (60) tick();

        // Zero dead time: triggers spaced W+1; check pulse every 16th, including the wrap to 0.
        dt = '0;
        for (int j = 0; j < 300 && m_cnt != 15; j++) fire(len);
        chk("pre16_cnt", 32'(eff_cnt_out), 32'd15);
        fire(len);
        chk("chk16_len", 32'(len), 32'(CPW));
        chk("chk16_cnt", 32'(eff_cnt_out), 32'd16);
        fire(len);
        chk("norm17_len", 32'(len), 32'(TPW));
        for (int j = 0; j < 300 && m_cnt != 255; j++) fire(len);
        chk("pre_wrap_cnt", 32'(eff_cnt_out), 32'd255);
        fire(len);
        chk("wrap_cnt", 32'(eff_cnt_out), 32'd0);
        chk("wrap_len", 32'(len), 32'(CPW));
        fire(len);
        chk("post_wrap_len", 32'(len), 32'(TPW));

        // Reset in the middle of a pulse.
        src = 3'b001; tick(); src = '0;
        repeat (5) tick();
        rst = 1; tick();
        chk("rmid_trg_n", 32'(trg_out_N), 32'({NO{1'b1}}));
        chk("rmid_cnt", 32'(eff_cnt_out), 32'd0);
        chk("rmid_lost", 32'(lost_cnt_out), 32'd0);
        chk("rmid_latch", 32'(latch_out), 32'd0);
        chk("rmid_busy", 32'(daq_busy_out), 32'd0);
        rst = 0; tick();
        fire(len);
        chk("after_rst_len", 32'(len), 32'(TPW));

        // Lost counter saturation.
        busy = 2'b01;
        for (int j = 0; j < 300; j++) begin
            src = 3'b001; tick();
            src = '0; tick();
        end
        chk("lost_sat", 32'(lost_cnt_out), 32'hFF);
        busy = '0;

        // Randomized traffic against the model.
        for (int j = 0; j < 4000; j++) begin
            src  = NS'($urandom);
            senb = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
            ten  = ($urandom_range(0, 9) != 0);
            busy = ($urandom_range(0, 5) == 0) ? NB'($urandom) : '0;
            mask = NB'($urandom);
            pmu  = ($urandom_range(0, 15) == 0);
            dt   = DTW'($urandom_range(0, 4));
            rst  = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
